filter_window_ctrl: RTL and testbench

Sequencer for the 49-tap (7×7) spatial filter datapath. It tracks pixel row and column in a raster stream and asserts the filter `enable` only when a full 7×7 window exists. It delays `enable` and frame/line markers through a shift register matched to the filter latency, so downstream logic receives qualified outputs. It also owns the double-buffered coefficient bank driving the filter's `c` input and swaps banks only between frames.

---
 rtl/filter_window_ctrl.sv | 148 ++++++++++++++
 tb/tb_filter_window_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_window_ctrl.sv
// Sequencer for the 7x7 spatial filter: raster row/col tracking, window-valid enable,
// latency-matched output qualifiers and a double-buffered coefficient bank.
module filter_window_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MASK_WIDTH = 7,
  parameter int COFCNT_BIT = 15,
  parameter int LATENCY    = 36
) (
  input  logic                                       clk,
  input  logic                                       reset_in,
  input  logic                                       pix_valid,
  input  logic                                       pix_sof,
  input  logic                                       coef_wr,
  input  logic [5:0]                                 coef_addr,
  input  logic [COFCNT_BIT-1:0]                      coef_data,
  input  logic                                       coef_swap,
  output logic [COFCNT_BIT*MASK_WIDTH*MASK_WIDTH-1:0] c,
  output logic                                       filt_enable,
  output logic                                       out_valid,
  output logic                                       out_sof,
  output logic                                       out_eol,
  output logic                                       swap_pending,
  output logic                                       busy,
  output logic                                       frame_done,
  output logic                                       sof_err
);

  localparam int TAPS  = MASK_WIDTH * MASK_WIDTH;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_WIN    = COL_W'(MASK_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_WIN    = ROW_W'(MASK_WIDTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, next_state;
  logic [COL_W-1:0]        col, cur_col;
  logic [ROW_W-1:0]        row, cur_row;
  logic [CNT_W-1:0]        drain_cnt;
  logic                    start, accept, last_pix, at_window, copy;
  logic [2:0]              dly_in;
  logic [2:0]              dly [LATENCY];
  logic [COFCNT_BIT-1:0]   shadow [TAPS];
  logic [COFCNT_BIT-1:0]   active [TAPS];

  // A sof pixel is always (0,0), whether it opens, restarts or follows a frame.
  assign start     = pix_valid & pix_sof;
  assign accept    = start | (pix_valid & (state == RUN));
  assign cur_col   = start ? '0 : col;
  assign cur_row   = start ? '0 : row;
  assign last_pix  = accept & (cur_row == ROW_LAST) & (cur_col == COL_LAST);
  assign at_window = (cur_row >= ROW_WIN) & (cur_col >= COL_WIN);
  assign copy      = swap_pending & ((state == IDLE) | (next_state == IDLE));

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, RUN: begin
        if (accept) next_state = last_pix ? DRAIN : RUN;
      end
      DRAIN: begin
        if (accept)                 next_state = last_pix ? DRAIN : RUN;
        else if (drain_cnt == '0)   next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    filt_enable = accept & at_window;
    busy        = (state != IDLE);
    frame_done  = (state == DRAIN) & (drain_cnt == '0) & ~accept;
    sof_err     = start & (state == RUN);
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        if (last_pix) begin
          col <= '0;
          row <= '0;
        end else if (cur_col == COL_LAST) begin
          col <= '0;
          row <= cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
      if (last_pix)                               drain_cnt <= DRAIN_LOAD;
      else if ((state == DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Free-running: the filter pipeline never stalls, so neither does its qualifier.
  assign dly_in = {filt_enable,
                   filt_enable & (cur_row == ROW_WIN) & (cur_col == COL_WIN),
                   filt_enable & (cur_col == COL_LAST)};

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      for (int unsigned i = 0; i < LATENCY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= dly_in;
      for (int unsigned i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  assign {out_valid, out_sof, out_eol} = dly[LATENCY-1];

  // Copy samples the pre-edge shadow, so a coincident write lands only in shadow.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      swap_pending <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (coef_wr && (int'(coef_addr) < TAPS)) shadow[coef_addr] <= coef_data;
      if (copy) begin
        for (int unsigned i = 0; i < TAPS; i++) active[i] <= shadow[i];
      end
      swap_pending <= coef_swap | (swap_pending & ~copy);
    end
  end

  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < TAPS; i++) c[i*COFCNT_BIT +: COFCNT_BIT] = active[i];
  end

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Scoreboard bench for filter_window_ctrl on a 10x8 image with 36-cycle filter latency.
module tb_filter_window_ctrl;

  localparam int W    = 10;
  localparam int H    = 8;
  localparam int M    = 7;
  localparam int CB   = 15;
  localparam int LAT  = 36;
  localparam int TAPS = M * M;

  logic                clk;
  logic                reset_in;
  logic                pix_valid, pix_sof, coef_wr, coef_swap;
  logic [5:0]          coef_addr;
  logic [CB-1:0]       coef_data;
  logic [CB*TAPS-1:0]  c;
  logic                filt_enable, out_valid, out_sof, out_eol;
  logic                swap_pending, busy, frame_done, sof_err;

  typedef struct {
    int   due;
    logic sof;
    logic eol;
  } exp_t;

  exp_t               sb[$];
  exp_t               mon_e;
  logic [CB*TAPS-1:0] exp_c;
  int asserts = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;
  int n_en = 0, n_valid = 0, n_sof = 0, n_eol = 0;

  filter_window_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .MASK_WIDTH(M), .COFCNT_BIT(CB), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_in(reset_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .c(c), .filt_enable(filt_enable), .out_valid(out_valid), .out_sof(out_sof),
    .out_eol(out_eol), .swap_pending(swap_pending), .busy(busy),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Output side of the scoreboard: every out_valid must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_in) begin
      if (out_valid) begin
        n_valid++;
        if (out_sof) n_sof++;
        if (out_eol) n_eol++;
        asserts++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL out_valid_unexpected: out_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.due !== cyc || mon_e.sof !== out_sof || mon_e.eol !== out_eol) begin
            failures++;
            $display("FAIL out_qual: cycle=%0d sof=%b eol=%b, required cycle=%0d sof=%b eol=%b",
                     cyc, out_sof, out_eol, mon_e.due, mon_e.sof, mon_e.eol);
          end
        end
      end else begin
        asserts++;
        if (out_sof !== 1'b0 || out_eol !== 1'b0) begin
          failures++;
          $display("FAIL tag_mask: out_sof=%b out_eol=%b with out_valid=0, required 0 0",
                   out_sof, out_eol);
        end
        if (sb.size() > 0) begin
          asserts++;
          if (sb[0].due <= cyc) begin
            failures++;
            $display("FAIL out_valid_missing: none at cycle %0d, required one at cycle %0d",
                     cyc, sb[0].due);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic send_pixel(input logic sof, input int r, input int cl, input logic exp_err);
    logic exp_en;
    exp_en = (r >= M - 1) && (cl >= M - 1);
    pix_valid = 1'b1;
    pix_sof   = sof;
    @(negedge clk);
    asserts++;
    if (filt_enable !== exp_en) begin
      failures++;
      $display("FAIL filt_enable(%0d,%0d): got %b, required %b", r, cl, filt_enable, exp_en);
    end
    asserts++;
    if (sof_err !== exp_err) begin
      failures++;
      $display("FAIL sof_err(%0d,%0d): got %b, required %b", r, cl, sof_err, exp_err);
    end
    asserts++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL frame_done_early(%0d,%0d): got %b, required 0", r, cl, frame_done);
    end
    asserts++;
    if (c !== exp_c) begin
      failures++;
      $display("FAIL c_stable(%0d,%0d): tap0 got %0d, required %0d", r, cl, c[CB-1:0], exp_c[CB-1:0]);
    end
    if (filt_enable) n_en++;
    if (exp_en) sb.push_back('{due: cyc + LAT, sof: (r == M - 1 && cl == M - 1), eol: (cl == W - 1)});
    last_cyc = cyc;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      @(negedge clk);
      asserts++;
      if (filt_enable !== 1'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs: filt_enable=%b frame_done=%b, required 0 0", filt_enable, frame_done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic gap, input logic first_err);
    for (int r = 0; r < H; r++) begin
      for (int cl = 0; cl < W; cl++) begin
        send_pixel(r == 0 && cl == 0, r, cl, (r == 0 && cl == 0) ? first_err : 1'b0);
        if (gap && !(r == H - 1 && cl == W - 1)) idle(1);
      end
    end
  endtask

  // Called right after the last pixel; frame_done is due LAT+1 cycles after it.
  task automatic wait_done(input logic [CB*TAPS-1:0] new_c);
    int t;
    t = last_cyc;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      asserts++;
      if (frame_done !== ((cyc - t) == LAT + 1)) begin
        failures++;
        $display("FAIL frame_done_timing: got %b at %0d cycles after last pixel, required %b",
                 frame_done, cyc - t, ((cyc - t) == LAT + 1));
      end
      asserts++;
      if (busy !== 1'b1 || c !== exp_c) begin
        failures++;
        $display("FAIL drain_state: busy=%b c_tap0=%0d, required busy=1 c_tap0=%0d",
                 busy, c[CB-1:0], exp_c[CB-1:0]);
      end
      @(posedge clk); #1;
    end
    exp_c = new_c;
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || c !== exp_c) begin
      failures++;
      $display("FAIL after_drain: busy=%b frame_done=%b c_tap48=%0d, required 0 0 %0d",
               busy, frame_done, c[48*CB +: CB], exp_c[48*CB +: CB]);
    end
    asserts++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL outputs_pending: %0d expected outputs outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string name, input int en0, input int v0, input int s0,
                              input int e0, input int en_req, input int v_req);
    asserts++;
    if (n_en - en0 !== en_req || n_valid - v0 !== v_req || n_sof - s0 !== v_req / 8
        || n_eol - e0 !== v_req / 4) begin
      failures++;
      $display("FAIL %s_counts: en=%0d valid=%0d sof=%0d eol=%0d, required %0d %0d %0d %0d",
               name, n_en - en0, n_valid - v0, n_sof - s0, n_eol - e0,
               en_req, v_req, v_req / 8, v_req / 4);
    end
  endtask

  task automatic write_coef(input int addr, input int data, input logic swap);
    coef_wr   = 1'b1;
    coef_addr = 6'(addr);
    coef_data = CB'(data);
    coef_swap = swap;
    @(posedge clk); #1;
    coef_wr   = 1'b0;
    coef_swap = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; coef_wr = 1'b0; coef_swap = 1'b0;
    coef_addr = '0; coef_data = '0;
    exp_c = '0;
    repeat (2) @(posedge clk);
    #1;
    asserts++;
    if ({filt_enable, out_valid, out_sof, out_eol, swap_pending, busy, frame_done, sof_err} !== 8'b0
        || c !== '0) begin
      failures++;
      $display("FAIL reset_outputs: flags=%b c_nonzero=%b, required 00000000 0",
               {filt_enable, out_valid, out_sof, out_eol, swap_pending, busy, frame_done, sof_err},
               (c != '0));
    end
    @(negedge clk) reset_in = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      asserts++;
      if (filt_enable !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_sof: filt_enable=%b busy=%b, required 0 0", filt_enable, busy);
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int en0, v0, s0, e0;
    en0 = n_en; v0 = n_valid; s0 = n_sof; e0 = n_eol;
    send_frame(1'b0, 1'b0);
    wait_done(exp_c);
    check_counts("full_frame", en0, v0, s0, e0, 8, 8);
  endtask

  task automatic test_gapped();
    int en0, v0, s0, e0;
    en0 = n_en; v0 = n_valid; s0 = n_sof; e0 = n_eol;
    send_frame(1'b1, 1'b0);
    wait_done(exp_c);
    check_counts("gapped", en0, v0, s0, e0, 8, 8);
  endtask

  task automatic test_coefs();
    logic [CB*TAPS-1:0] new_c;
    logic               exp_pend;
    new_c = '0;
    for (int i = 0; i < TAPS; i++) begin
      write_coef(i, i + 1, 1'b0);
      new_c[i*CB +: CB] = CB'(i + 1);
    end
    write_coef(49, 7777, 1'b0);
    write_coef(63, 7777, 1'b0);
    asserts++;
    if (c !== exp_c || swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL shadow_only: c_tap0=%0d pending=%b, required 0 0", c[CB-1:0], swap_pending);
    end
    exp_pend = 1'b0;
    for (int r = 0; r < H; r++) begin
      for (int cl = 0; cl < W; cl++) begin
        asserts++;
        if (swap_pending !== exp_pend) begin
          failures++;
          $display("FAIL swap_pending_run(%0d,%0d): got %b, required %b", r, cl, swap_pending, exp_pend);
        end
        coef_swap = (r == 2 && cl == 3);
        send_pixel(r == 0 && cl == 0, r, cl, 1'b0);
        coef_swap = 1'b0;
        if (r == 2 && cl == 3) exp_pend = 1'b1;
      end
    end
    wait_done(new_c);
    asserts++;
    if (swap_pending !== 1'b0 || c[48*CB +: CB] !== CB'(49)) begin
      failures++;
      $display("FAIL swap_applied: pending=%b tap48=%0d, required 0 49", swap_pending, c[48*CB +: CB]);
    end
    // Write and copy on the same edge: copy must take the older shadow value.
    write_coef(0, 100, 1'b1);
    asserts++;
    if (swap_pending !== 1'b1 || c !== exp_c) begin
      failures++;
      $display("FAIL swap_request: pending=%b tap0=%0d, required 1 %0d", swap_pending, c[CB-1:0], exp_c[CB-1:0]);
    end
    write_coef(0, 200, 1'b0);
    exp_c[0 +: CB] = CB'(100);
    asserts++;
    if (swap_pending !== 1'b0 || c !== exp_c) begin
      failures++;
      $display("FAIL write_copy_same_edge: pending=%b tap0=%0d, required 0 100", swap_pending, c[CB-1:0]);
    end
    coef_swap = 1'b1;
    @(posedge clk); #1;
    coef_swap = 1'b0;
    @(posedge clk); #1;
    exp_c[0 +: CB] = CB'(200);
    asserts++;
    if (swap_pending !== 1'b0 || c !== exp_c) begin
      failures++;
      $display("FAIL second_swap: pending=%b tap0=%0d, required 0 200", swap_pending, c[CB-1:0]);
    end
  endtask

  task automatic test_mid_sof();
    int en0, v0, s0, e0;
    en0 = n_en; v0 = n_valid; s0 = n_sof; e0 = n_eol;
    for (int k = 0; k < 3 * W + 2; k++) send_pixel(k == 0, k / W, k % W, 1'b0);
    send_frame(1'b0, 1'b1);
    wait_done(exp_c);
    check_counts("mid_sof", en0, v0, s0, e0, 8, 8);
  endtask

  task automatic test_sof_drain();
    int en0, v0, s0, e0;
    en0 = n_en; v0 = n_valid; s0 = n_sof; e0 = n_eol;
    send_frame(1'b0, 1'b0);
    idle(5);
    asserts++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL drain_busy: got %b, required 1", busy);
    end
    send_frame(1'b0, 1'b0);
    wait_done(exp_c);
    check_counts("sof_drain", en0, v0, s0, e0, 16, 16);
  endtask

  task automatic test_reset_drain();
    int v0;
    send_frame(1'b0, 1'b0);
    idle(3);
    v0 = n_valid;
    #2 reset_in = 1'b0;
    #1;
    asserts++;
    if ({out_valid, out_sof, out_eol, swap_pending, busy, frame_done, filt_enable, sof_err} !== 8'b0
        || c !== '0) begin
      failures++;
      $display("FAIL async_reset: flags=%b c_tap48=%0d, required 00000000 0",
               {out_valid, out_sof, out_eol, swap_pending, busy, frame_done, filt_enable, sof_err},
               c[48*CB +: CB]);
    end
    sb.delete();
    exp_c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_in = 1'b1;
    @(posedge clk); #1;
    idle(LAT + 14);
    asserts++;
    if (n_valid != v0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_flush: %0d out_valid busy=%b, required 0 0", n_valid - v0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gapped();
    test_coefs();
    test_mid_sof();
    test_sof_drain();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
